uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side buffer placed directly downstream of the UART receiver.
- Captures each received byte and its parity/frame error flags on the receiver's one-cycle valid pulse.
- Stores entries in a first-word-fall-through (FWFT) FIFO and presents them to the consumer over a valid/ready handshake.
- Keeps a sticky overflow flag and saturating error counters for software/status logic.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 2.
- DROP_ERR, 0, when 1, frames carrying parity or frame error are counted but not stored.
- CNT_W, 8, width of each error counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_data  in  8  received byte
- wr_valid  in  1  one-cycle pulse: wr_data/flags valid this cycle
- wr_parity_err  in  1  parity error of this frame
- wr_frame_err  in  1  stop-bit error of this frame
- rd_data  out  8  head-entry byte
- rd_parity_err  out  1  head-entry parity flag
- rd_frame_err  out  1  head-entry frame flag
- rd_valid  out  1  FIFO not empty; head fields valid
- rd_ready  in  1  consumer accepts head
- count  out  $clog2(DEPTH+1)  entries stored
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: a storable frame was lost because the FIFO was full
- ovf_clr  in  1  clear overflow
- parity_err_cnt  out  CNT_W  saturating count of frames with parity error
- frame_err_cnt  out  CNT_W  saturating count of frames with frame error
- cnt_clr  in  1  clear both counters

Behaviour:
- Interface decision: one clock (clk); asynchronous active-low reset (rst_n).
- Reset values:
  - Pointers, count, overflow and both counters are 0.
  - empty=1, full=0, rd_valid=0.
  - Storage contents are don't-care; rd_data/rd_* flags read 0 while empty.
- Entry format: {frame_err, parity_err, data[7:0]}, 10 bits.
- Storable frame: wr_valid && !(DROP_ERR && (wr_parity_err || wr_frame_err)).
- Push: storable && (!full || pop).
  - Entry written at the write pointer; pointer increments modulo DEPTH.
- Pop: rd_valid && rd_ready.
  - Read pointer increments modulo DEPTH.
  - rd_* reflect the new head in the next cycle (FWFT, combinational from storage at the read pointer).
- Latency: a push into an empty FIFO gives rd_valid=1 the following cycle. A pop cannot occur in the same cycle as a push into an empty FIFO.
- Simultaneous push and pop: count unchanged. This also applies when full: the write is accepted, with no overflow.
- Pointers: log2(DEPTH)+1 bits each.
  - full = MSBs differ and LSBs equal.
  - empty = pointers equal.
  - count = wr_ptr - rd_ptr.
  - Wrap-around of both pointers is exercised by normal operation.
- Overflow:
  - Set when storable && full && !pop; the frame is discarded and FIFO contents are unchanged.
  - Cleared by ovf_clr; if set and clear coincide, set wins.
  - A frame dropped by DROP_ERR never sets overflow.
- Error counters:
  - Each increments by 1 on wr_valid with its flag high, independent of storage, drop or overflow.
  - Both increment if both flags are high.
  - Each saturates at 2^CNT_W-1.
  - cnt_clr zeroes them; if clear and increment coincide, the result is 1.
- rd_ready with rd_valid=0 is ignored.
- wr_valid held high on consecutive cycles: each cycle is a separate frame.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); in-flight frames are lost.

Test Plan:
- Push 0xA5, 0x3C (no errors), then rd_ready=1 -> rd_valid rises 1 cycle after the first push; rd_data 0xA5 then 0x3C; count 1,2,1,0; empty=1 at end.
- DEPTH=4: push 0x01..0x04 with rd_ready=0 -> full=1, count=4. Push 0x05 -> overflow=1, contents unchanged. Pop all -> 0x01..0x04. Pulse ovf_clr -> overflow=0.
- DEPTH=4, full: push 0x06 and pop in the same cycle -> no overflow, count stays 4. Drain -> 0x02,0x03,0x04,0x06 (checks pointer wrap).
- Push 0x55 with parity_err=1, then 0x66 with frame_err=1, DROP_ERR=0 -> both stored with matching rd_* flags; parity_err_cnt=1, frame_err_cnt=1. Repeat with DROP_ERR=1 -> nothing stored, empty stays 1, counters 2/2, overflow 0.
- CNT_W=2: 5 parity-error frames -> parity_err_cnt saturates at 3. cnt_clr coincident with a parity-error frame -> counter reads 1.
- Fill with 3 entries, assert rst_n=0 mid-stream -> count=0, empty=1, rd_valid=0, overflow=0, counters 0 without waiting for a clock edge.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer for a UART receiver: stores {frame_err, parity_err, data}
// per frame, tracks sticky overflow and saturating parity/frame error counters.
module uart_rx_fifo #(
  parameter int unsigned DEPTH    = 16,
  parameter bit          DROP_ERR = 1'b0,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 wr_data,
  input  logic                       wr_valid,
  input  logic                       wr_parity_err,
  input  logic                       wr_frame_err,
  output logic [7:0]                 rd_data,
  output logic                       rd_parity_err,
  output logic                       rd_frame_err,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       ovf_clr,
  output logic [CNT_W-1:0]           parity_err_cnt,
  output logic [CNT_W-1:0]           frame_err_cnt,
  input  logic                       cnt_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [9:0]       r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             r_overflow;
  logic [CNT_W-1:0] r_pe_cnt;
  logic [CNT_W-1:0] r_fe_cnt;

  logic             w_storable;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_set;
  logic             w_pe_inc;
  logic             w_fe_inc;
  logic [CNT_W-1:0] w_pe_nxt;
  logic [CNT_W-1:0] w_fe_nxt;
  logic [9:0]       w_head;

  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count    = r_wr_ptr - r_rd_ptr;
  assign rd_valid = !empty;

  assign w_storable = wr_valid && !(DROP_ERR && (wr_parity_err || wr_frame_err));
  assign w_pop      = rd_valid && rd_ready;
  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign w_push     = w_storable && (!full || w_pop);
  assign w_ovf_set  = w_storable && full && !w_pop;
  assign w_pe_inc   = wr_valid && wr_parity_err;
  assign w_fe_inc   = wr_valid && wr_frame_err;

  assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
  assign rd_data       = empty ? '0 : w_head[7:0];
  assign rd_parity_err = empty ? 1'b0 : w_head[8];
  assign rd_frame_err  = empty ? 1'b0 : w_head[9];

  assign overflow       = r_overflow;
  assign parity_err_cnt = r_pe_cnt;
  assign frame_err_cnt  = r_fe_cnt;

  // Clear coinciding with an error frame leaves the counter at 1.
  always_comb begin
    w_pe_nxt = r_pe_cnt;
    if (cnt_clr)
      w_pe_nxt = CNT_W'(w_pe_inc);
    else if (w_pe_inc && (r_pe_cnt != '1))
      w_pe_nxt = r_pe_cnt + CNT_W'(1);
  end

  always_comb begin
    w_fe_nxt = r_fe_cnt;
    if (cnt_clr)
      w_fe_nxt = CNT_W'(w_fe_inc);
    else if (w_fe_inc && (r_fe_cnt != '1))
      w_fe_nxt = r_fe_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr[AW-1:0]] <= {wr_frame_err, wr_parity_err, wr_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_pe_cnt   <= '0;
      r_fe_cnt   <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_ovf_set)
        r_overflow <= 1'b1;
      else if (ovf_clr)
        r_overflow <= 1'b0;
      r_pe_cnt <= w_pe_nxt;
      r_fe_cnt <= w_fe_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: two DEPTH=4, CNT_W=2 instances (DROP_ERR 0 and 1) sharing stimulus.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_parity_err;
  logic       wr_frame_err;
  logic       rd_ready;
  logic       ovf_clr;
  logic       cnt_clr;

  logic [7:0] a_rd_data, b_rd_data;
  logic       a_rd_pe, b_rd_pe, a_rd_fe, b_rd_fe, a_rd_valid, b_rd_valid;
  logic [2:0] a_count, b_count;
  logic       a_full, b_full, a_empty, b_empty, a_ovf, b_ovf;
  logic [1:0] a_pe_cnt, b_pe_cnt, a_fe_cnt, b_fe_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  uart_rx_fifo #(.DEPTH(4), .DROP_ERR(1'b0), .CNT_W(2)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_parity_err(wr_parity_err), .wr_frame_err(wr_frame_err),
    .rd_data(a_rd_data), .rd_parity_err(a_rd_pe), .rd_frame_err(a_rd_fe),
    .rd_valid(a_rd_valid), .rd_ready(rd_ready), .count(a_count),
    .full(a_full), .empty(a_empty), .overflow(a_ovf), .ovf_clr(ovf_clr),
    .parity_err_cnt(a_pe_cnt), .frame_err_cnt(a_fe_cnt), .cnt_clr(cnt_clr)
  );

  uart_rx_fifo #(.DEPTH(4), .DROP_ERR(1'b1), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_parity_err(wr_parity_err), .wr_frame_err(wr_frame_err),
    .rd_data(b_rd_data), .rd_parity_err(b_rd_pe), .rd_frame_err(b_rd_fe),
    .rd_valid(b_rd_valid), .rd_ready(rd_ready), .count(b_count),
    .full(b_full), .empty(b_empty), .overflow(b_ovf), .ovf_clr(ovf_clr),
    .parity_err_cnt(b_pe_cnt), .frame_err_cnt(b_fe_cnt), .cnt_clr(cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rdy;
    logic       oc;
    logic       ev;
    logic [7:0] ed;
    logic [2:0] ecnt;
    logic       efull;
    logic       eovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic wv, logic [7:0] wd, logic rdy, logic oc,
                             logic ev, logic [7:0] ed, logic [2:0] ecnt,
                             logic efull, logic eovf);
    vec_t r;
    r.wv = wv; r.wd = wd; r.rdy = rdy; r.oc = oc;
    r.ev = ev; r.ed = ed; r.ecnt = ecnt; r.efull = efull; r.eovf = eovf;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; wr_data = 8'h00; wr_parity_err = 1'b0; wr_frame_err = 1'b0;
    rd_ready = 1'b0; ovf_clr = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic frame(input logic [7:0] d, input logic pe, input logic fe);
    wr_valid = 1'b1; wr_data = d; wr_parity_err = pe; wr_frame_err = fe;
    step();
    wr_valid = 1'b0; wr_parity_err = 1'b0; wr_frame_err = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst_count", a_count, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_full", a_full, 0);
    chk("rst_valid", a_rd_valid, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_data", a_rd_data, 0);
    chk("rst_pecnt", a_pe_cnt, 0);
    rst_n = 1'b1;
    step();

    // basic FWFT, overflow, full push+pop with pointer wrap, set/clear overflow priority
    tbl.push_back(v(1, 8'hA5, 0, 0, 1, 8'hA5, 1, 0, 0));
    tbl.push_back(v(1, 8'h3C, 0, 0, 1, 8'hA5, 2, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 1, 8'h3C, 1, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(v(1, 8'h01, 0, 0, 1, 8'h01, 1, 0, 0));
    tbl.push_back(v(1, 8'h02, 0, 0, 1, 8'h01, 2, 0, 0));
    tbl.push_back(v(1, 8'h03, 0, 0, 1, 8'h01, 3, 0, 0));
    tbl.push_back(v(1, 8'h04, 0, 0, 1, 8'h01, 4, 1, 0));
    tbl.push_back(v(1, 8'h05, 0, 0, 1, 8'h01, 4, 1, 1));
    tbl.push_back(v(0, 8'h00, 1, 0, 1, 8'h02, 3, 0, 1));
    tbl.push_back(v(0, 8'h00, 1, 0, 1, 8'h03, 2, 0, 1));
    tbl.push_back(v(0, 8'h00, 1, 0, 1, 8'h04, 1, 0, 1));
    tbl.push_back(v(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(v(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(v(1, 8'h01, 0, 0, 1, 8'h01, 1, 0, 0));
    tbl.push_back(v(1, 8'h02, 0, 0, 1, 8'h01, 2, 0, 0));
    tbl.push_back(v(1, 8'h03, 0, 0, 1, 8'h01, 3, 0, 0));
    tbl.push_back(v(1, 8'h04, 0, 0, 1, 8'h01, 4, 1, 0));
    tbl.push_back(v(1, 8'h06, 1, 0, 1, 8'h02, 4, 1, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 1, 8'h03, 3, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 1, 8'h04, 2, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 1, 8'h06, 1, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(v(1, 8'h11, 0, 0, 1, 8'h11, 1, 0, 0));
    tbl.push_back(v(1, 8'h12, 0, 0, 1, 8'h11, 2, 0, 0));
    tbl.push_back(v(1, 8'h13, 0, 0, 1, 8'h11, 3, 0, 0));
    tbl.push_back(v(1, 8'h14, 0, 0, 1, 8'h11, 4, 1, 0));
    tbl.push_back(v(1, 8'h15, 0, 1, 1, 8'h11, 4, 1, 1));
    tbl.push_back(v(0, 8'h00, 0, 1, 1, 8'h11, 4, 1, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 1, 8'h12, 3, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 1, 8'h13, 2, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 1, 8'h14, 1, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));

    foreach (tbl[i]) begin
      wr_valid = tbl[i].wv; wr_data = tbl[i].wd;
      rd_ready = tbl[i].rdy; ovf_clr = tbl[i].oc;
      step();
      chk($sformatf("v%0d_valid", i), a_rd_valid, tbl[i].ev);
      chk($sformatf("v%0d_data", i), a_rd_data, tbl[i].ed);
      chk($sformatf("v%0d_count", i), a_count, tbl[i].ecnt);
      chk($sformatf("v%0d_full", i), a_full, tbl[i].efull);
      chk($sformatf("v%0d_empty", i), a_empty, (tbl[i].ecnt == 0));
      chk($sformatf("v%0d_ovf", i), a_ovf, tbl[i].eovf);
    end
    idle_inputs();

    // error flags stored (DROP_ERR=0) vs dropped (DROP_ERR=1)
    do_reset();
    frame(8'h55, 1, 0);
    frame(8'h66, 0, 1);
    chk("err_a_count", a_count, 2);
    chk("err_a_data0", a_rd_data, 8'h55);
    chk("err_a_pe0", a_rd_pe, 1);
    chk("err_a_fe0", a_rd_fe, 0);
    chk("err_a_pecnt", a_pe_cnt, 1);
    chk("err_a_fecnt", a_fe_cnt, 1);
    chk("err_b_empty", b_empty, 1);
    chk("err_b_count", b_count, 0);
    chk("err_b_pecnt", b_pe_cnt, 1);
    chk("err_b_fecnt", b_fe_cnt, 1);
    chk("err_b_ovf", b_ovf, 0);
    rd_ready = 1'b1;
    step();
    chk("err_a_data1", a_rd_data, 8'h66);
    chk("err_a_pe1", a_rd_pe, 0);
    chk("err_a_fe1", a_rd_fe, 1);
    step();
    chk("err_a_drained", a_empty, 1);
    rd_ready = 1'b0;
    frame(8'h55, 1, 0);
    frame(8'h66, 0, 1);
    chk("err2_b_empty", b_empty, 1);
    chk("err2_b_pecnt", b_pe_cnt, 2);
    chk("err2_b_fecnt", b_fe_cnt, 2);
    chk("err2_a_count", a_count, 2);
    for (int k = 0; k < 4; k++) frame(8'h70 + 8'(k), 0, 0);
    chk("fill_a_ovf", a_ovf, 1);
    chk("fill_b_full", b_full, 1);
    chk("fill_b_ovf", b_ovf, 0);
    frame(8'h77, 1, 1);
    chk("drop_b_ovf", b_ovf, 0);
    chk("drop_b_count", b_count, 4);
    chk("drop_b_head", b_rd_data, 8'h70);
    chk("both_b_pecnt", b_pe_cnt, 3);
    chk("both_b_fecnt", b_fe_cnt, 3);
    chk("both_a_pecnt", a_pe_cnt, 3);
    chk("both_a_fecnt", a_fe_cnt, 3);

    // counter saturation and clear/increment coincidence
    do_reset();
    rd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      frame(8'h20 + 8'(k), 1, 0);
      chk($sformatf("sat%0d_pecnt", k), a_pe_cnt, (k < 3) ? k + 1 : 3);
    end
    chk("sat_fecnt", a_fe_cnt, 0);
    cnt_clr = 1'b1;
    frame(8'h30, 1, 0);
    chk("clr_inc_pecnt", a_pe_cnt, 1);
    chk("clr_inc_fecnt", a_fe_cnt, 0);
    step();
    cnt_clr = 1'b0;
    chk("clr_pecnt", a_pe_cnt, 0);
    rd_ready = 1'b0;
    step();

    // asynchronous reset mid-stream
    frame(8'h01, 0, 0);
    frame(8'h02, 0, 0);
    frame(8'h03, 1, 1);
    chk("pre_rst_count", a_count, 3);
    frame(8'h04, 0, 0);
    frame(8'h05, 0, 0);
    chk("pre_rst_ovf", a_ovf, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_count", a_count, 0);
    chk("arst_empty", a_empty, 1);
    chk("arst_valid", a_rd_valid, 0);
    chk("arst_ovf", a_ovf, 0);
    chk("arst_pecnt", a_pe_cnt, 0);
    chk("arst_fecnt", a_fe_cnt, 0);
    chk("arst_data", a_rd_data, 0);
    chk("arst_full", a_full, 0);
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
